// File: rtl/sc_stream_sched_if.sv
// Bundle of request-side and SC-generator-side signals for sc_stream_sched.
// Latency: none (wires only).
// Backpressure: none; requesters hold req level until their done pulse.
//
// master: the environment (requesters + SC generator) driving the scheduler.
// slave : the scheduler itself.
// err is present only when SC_STREAM_SCHED_WDOG_EN is defined.
interface sc_stream_sched_if #(
    parameter int NREQ = 4,
    parameter int CW   = 7
);
    logic [NREQ-1:0]   req;
    logic [NREQ*6-1:0] req_num;
    logic [35:0]       cfg_m;
    logic [NREQ-1:0]   gnt;
    logic              done;
    logic [2:0]        done_id;
    logic [CW-1:0]     done_cnt;
    logic              busy;
    logic              sc_en_in;
    logic [5:0]        sc_num;
    logic [35:0]       sc_m;
    logic              sc_en_out;
    logic              sc_seq;
`ifdef SC_STREAM_SCHED_WDOG_EN
    logic              err;
`endif

    modport master (
        output req, req_num, cfg_m, sc_en_out, sc_seq,
        input  gnt, done, done_id, done_cnt, busy, sc_en_in, sc_num, sc_m
`ifdef SC_STREAM_SCHED_WDOG_EN
        , input err
`endif
    );

    modport slave (
        input  req, req_num, cfg_m, sc_en_out, sc_seq,
        output gnt, done, done_id, done_cnt, busy, sc_en_in, sc_num, sc_m
`ifdef SC_STREAM_SCHED_WDOG_EN
        , output err
`endif
    );
endinterface

// File: rtl/sc_stream_sched.sv
// Round-robin scheduler sharing one Sobol SC bitstream generator; counts ones of LEN valid bits per job.
// Latency: done = GRANT + SC pipeline delay + LEN valid strobes + 1 cycle.
// Backpressure: req is a held level; new requests wait in IDLE, sc_en_out gaps simply stretch RUN.
//
// Ports: clk, rst (async active-low), bus (sc_stream_sched_if.slave): req/req_num/cfg_m in,
// gnt/done/done_id/done_cnt/busy out, sc_en_in/sc_num/sc_m to generator, sc_en_out/sc_seq from it.
// Optional: define SC_STREAM_SCHED_WDOG_EN for the RUN watchdog (TO_CYC cycles) and the err output.
module sc_stream_sched #(
    parameter int NREQ   = 4,
    parameter int LEN    = 64,
    parameter int CW     = 7,
    parameter int TO_CYC = 255
) (
    input  logic             clk,
    input  logic             rst,
    sc_stream_sched_if.slave bus
);
    typedef enum logic [1:0] {IDLE, GRANT, RUN, DONE} state_t;

    state_t        state_q, state_d;
    logic [2:0]    sel_q, rr_q, pick;
    logic          found;
    logic [CW-1:0] vcnt_q, ones_q, vcnt_inc, ones_inc;
    logic [5:0]    num_q, num_sel;
    logic [35:0]   m_q;
    logic [2:0]    done_id_q;
    logic [CW-1:0] done_cnt_q;
    logic [NREQ-1:0] gnt;
    logic          busy, done, sc_en_in, last_bit;

`ifdef SC_STREAM_SCHED_WDOG_EN
    localparam int WW = $clog2(TO_CYC + 1);
    logic [WW-1:0] wcnt_q;
    logic          to_q, wdog_hit;
    // Counter value k means k cycles since GRANT (or since the last strobe);
    // firing one short of TO_CYC makes DONE land exactly TO_CYC cycles out.
    assign wdog_hit = !bus.sc_en_out && (wcnt_q == WW'(TO_CYC - 1));
    assign bus.err  = (state_q == DONE) && to_q;
`endif

    // First set req at or above the rr pointer, wrapping. Scanning offsets
    // outward with constant candidate indices keeps every select static.
    always_comb begin
        pick  = '0;
        found = 1'b0;
        for (int d = 0; d < NREQ; d++) begin
            for (int c = 0; c < NREQ; c++) begin
                if (!found && bus.req[c] && (((int'(rr_q) + d) % NREQ) == c)) begin
                    found = 1'b1;
                    pick  = 3'(c);
                end
            end
        end
    end

    always_comb begin
        num_sel = '0;
        for (int c = 0; c < NREQ; c++) begin
            if (sel_q == 3'(c)) num_sel = bus.req_num[6*c +: 6];
        end
    end

    assign vcnt_inc = vcnt_q + 1'b1;
    assign ones_inc = ones_q + CW'(bus.sc_seq);
    assign last_bit = bus.sc_en_out && (vcnt_inc == CW'(LEN));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        gnt      = '0;
        busy     = 1'b0;
        done     = 1'b0;
        sc_en_in = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (found) state_d = GRANT;
            end
            GRANT: begin
                busy = 1'b1;
                for (int c = 0; c < NREQ; c++) gnt[c] = (sel_q == 3'(c));
                state_d = RUN;
            end
            RUN: begin
                busy     = 1'b1;
                sc_en_in = 1'b1;
                if (last_bit) state_d = DONE;
`ifdef SC_STREAM_SCHED_WDOG_EN
                else if (wdog_hit) state_d = DONE;
`endif
            end
            DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sel_q      <= '0;
            rr_q       <= '0;
            vcnt_q     <= '0;
            ones_q     <= '0;
            num_q      <= '0;
            m_q        <= '0;
            done_id_q  <= '0;
            done_cnt_q <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (found) sel_q <= pick;
                end
                GRANT: begin
                    num_q  <= num_sel;
                    m_q    <= bus.cfg_m;
                    vcnt_q <= '0;
                    ones_q <= '0;
                    rr_q   <= (sel_q == 3'(NREQ - 1)) ? 3'd0 : sel_q + 3'd1;
                end
                RUN: begin
                    if (bus.sc_en_out) begin
                        vcnt_q <= vcnt_inc;
                        ones_q <= ones_inc;
                    end
                    // Result registers outlive the job so done_id/done_cnt hold after done.
                    if (state_d == DONE) begin
                        done_id_q  <= sel_q;
                        done_cnt_q <= bus.sc_en_out ? ones_inc : ones_q;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef SC_STREAM_SCHED_WDOG_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wcnt_q <= '0;
            to_q   <= 1'b0;
        end else if (state_q == GRANT) begin
            wcnt_q <= WW'(1);
            to_q   <= 1'b0;
        end else if (state_q == RUN) begin
            wcnt_q <= bus.sc_en_out ? '0 : wcnt_q + 1'b1;
            if (state_d == DONE && !last_bit) to_q <= 1'b1;
        end
    end
`endif

    assign bus.gnt      = gnt;
    assign bus.busy     = busy;
    assign bus.done     = done;
    assign bus.sc_en_in = sc_en_in;
    assign bus.sc_num   = num_q;
    assign bus.sc_m     = m_q;
    assign bus.done_id  = done_id_q;
    assign bus.done_cnt = done_cnt_q;
endmodule

// File: tb/tb_sc_stream_sched.sv
// Self-checking bench for sc_stream_sched with a behavioural SC generator stand-in.
// The stand-in emits bit k of a job as (bitrev6(k) < num), a van der Corput
// sequence, so a full 64-bit period holds exactly num ones.
module tb_sc_stream_sched;
    localparam int NREQ   = 4;
    localparam int LEN    = 64;
    localparam int CW     = 7;
    localparam int TO_CYC = 16;

    logic clk;
    logic rst;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    sc_stream_sched_if #(.NREQ(NREQ), .CW(CW)) bus();

    sc_stream_sched #(.NREQ(NREQ), .LEN(LEN), .CW(CW), .TO_CYC(TO_CYC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int failures = 0;

    logic [NREQ-1:0] pend;
    logic [5:0]      nums [NREQ];
    logic [35:0]     cfg;
    int              rr_m;
    int              last_id;
    bit              stall;
    int              sc_k;
    int              dly;
    int              done_total = 0;
    int              gnt_total = 0;
    int              gap_viol = 0;
    int              proto_viol = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [5:0] bitrev6(input logic [5:0] v);
        return {v[0], v[1], v[2], v[3], v[4], v[5]};
    endfunction

    // Next requester to be served from pointer p under round-robin rules.
    function automatic int rr_pick(input logic [NREQ-1:0] r, input int p);
        for (int d = 0; d < NREQ; d++) begin
            if (r[(p + d) % NREQ]) return (p + d) % NREQ;
        end
        return 0;
    endfunction

    task automatic drive();
        bus.req   = pend;
        bus.cfg_m = cfg;
        for (int i = 0; i < NREQ; i++) bus.req_num[6*i +: 6] = nums[i];
    endtask

    task automatic new_cfg();
        cfg[31:0]  = $urandom;
        cfg[35:32] = 4'($urandom_range(0, 15));
    endtask

    task automatic wait_gnt(output bit ok, output int id, output logic [NREQ-1:0] gv);
        ok = 0; id = -1; gv = '0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (|bus.gnt) begin
                ok = 1;
                gv = bus.gnt;
                for (int i = 0; i < NREQ; i++) if (bus.gnt[i]) id = i;
                break;
            end
        end
    endtask

    task automatic wait_done(output bit ok, output int id, output int cnt);
        ok = 0; id = -1; cnt = -1;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (bus.done) begin
                ok = 1;
                id = int'(bus.done_id);
                cnt = int'(bus.done_cnt);
                break;
            end
        end
    endtask

    // One full job against the model: expected grantee from the rr rule,
    // expected count = num captured at grant (full period, LEN=64).
    task automatic run_job(input string tag);
        bit ok;
        int gid, did, dcnt, exp_id;
        logic [NREQ-1:0] gv;
        logic [35:0] exp_m;
        logic [5:0]  exp_num;
        exp_id = rr_pick(pend, rr_m);
        wait_gnt(ok, gid, gv);
        chk({tag, ":gnt_seen"}, 64'(ok), 64'd1);
        if (!ok) return;
        chk({tag, ":gnt"}, 64'(gv), 64'(1 << exp_id));
        rr_m    = (exp_id + 1) % NREQ;
        last_id = exp_id;
        exp_num = nums[exp_id];
        exp_m   = cfg;
        @(negedge clk);
        new_cfg();
        drive();
        wait_done(ok, did, dcnt);
        chk({tag, ":done_seen"}, 64'(ok), 64'd1);
        chk({tag, ":done_id"}, 64'(did), 64'(exp_id));
        chk({tag, ":done_cnt"}, 64'(dcnt), 64'(exp_num));
        chk({tag, ":sc_m"}, 64'(bus.sc_m), 64'(exp_m));
`ifdef SC_STREAM_SCHED_WDOG_EN
        chk({tag, ":err"}, 64'(bus.err), 64'd0);
`endif
    endtask

    // SC generator stand-in: 2-cycle start-up delay, random strobe gaps,
    // sequence restarts whenever sc_en_in is low.
    initial begin
        bus.sc_en_out = 1'b0;
        bus.sc_seq    = 1'b0;
        sc_k = 0;
        dly  = 0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst || !bus.sc_en_in) begin
                sc_k = 0; dly = 0;
                bus.sc_en_out = 1'b0;
                bus.sc_seq    = 1'b0;
            end else if (dly < 2) begin
                dly++;
                bus.sc_en_out = 1'b0;
            end else if (stall || $urandom_range(0, 3) == 0) begin
                bus.sc_en_out = 1'b0;
                bus.sc_seq    = 1'($urandom_range(0, 1));
            end else begin
                bus.sc_en_out = 1'b1;
                bus.sc_seq    = (bitrev6(6'(sc_k)) < bus.sc_num);
                sc_k++;
            end
        end
    end

    // Protocol monitor: one-hot gnt, busy around gnt/done, >=2 low cycles of sc_en_in between jobs.
    initial begin
        bit prev_en = 0;
        bit started = 0;
        int low_run = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                if ((|bus.gnt) && !$onehot(bus.gnt)) proto_viol++;
                if (((|bus.gnt) || bus.done) && !bus.busy) proto_viol++;
                if (bus.done) done_total++;
                if (|bus.gnt) gnt_total++;
            end
            if (bus.sc_en_in) begin
                if (!prev_en && started && low_run < 2) gap_viol++;
                started = 1;
                low_run = 0;
            end else begin
                low_run++;
            end
            prev_en = bus.sc_en_in;
        end
    end

    initial begin
        bit ok;
        int gid, did, dcnt, d0, g0, lat, lcnt, lerr;
        logic [NREQ-1:0] gv;

        rst = 1'b0; stall = 0; pend = '0; cfg = '0; rr_m = 0; last_id = 0;
        for (int i = 0; i < NREQ; i++) nums[i] = '0;
        drive();
        repeat (3) @(negedge clk);
        chk("rst:gnt", 64'(bus.gnt), 64'd0);
        chk("rst:done", 64'(bus.done), 64'd0);
        chk("rst:busy", 64'(bus.busy), 64'd0);
        chk("rst:sc_en_in", 64'(bus.sc_en_in), 64'd0);
        chk("rst:res", 64'({bus.done_id, bus.done_cnt, bus.sc_num}), 64'd0);
        chk("rst:sc_m", 64'(bus.sc_m), 64'd0);
        rst = 1'b1;

        // No requests: stay quiet.
        g0 = gnt_total;
        repeat (10) @(negedge clk);
        chk("idle:no_gnt", 64'(gnt_total - g0), 64'd0);
        chk("idle:busy", 64'(bus.busy), 64'd0);

        // Single requester, num=0, exactly one done.
        d0 = done_total;
        pend = 4'b0001; nums[0] = 6'd0; new_cfg(); drive();
        run_job("s1");
        pend = '0; drive();
        repeat (10) @(negedge clk);
        chk("s1:one_done", 64'(done_total - d0), 64'd1);

        // Back-to-back jobs from one requester, num 63 then 32.
        pend = 4'b0001; nums[0] = 6'd63; drive();
        run_job("s2a");
        nums[0] = 6'd32; drive();
        run_job("s2b");
        pend = '0; drive();
        repeat (4) @(negedge clk);

        // Fresh reset, all four requesting: order 0,1,2,3,0.
        rst = 1'b0; @(negedge clk); rst = 1'b1; rr_m = 0;
        pend = 4'b1111;
        nums[0] = 6'd10; nums[1] = 6'd20; nums[2] = 6'd30; nums[3] = 6'd40;
        drive();
        for (int j = 0; j < 5; j++) run_job("s3");
        pend = '0; drive();
        repeat (4) @(negedge clk);

        // Randomized traffic.
        for (int j = 0; j < 16; j++) begin
            if (pend == '0) pend = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            drive();
            run_job("rnd");
            if ($urandom_range(0, 1) == 1) pend[last_id] = 1'b0;
            pend = pend | NREQ'($urandom_range(0, (1 << NREQ) - 1));
            for (int i = 0; i < NREQ; i++) nums[i] = 6'($urandom_range(0, 63));
        end
        pend = '0; drive();
        repeat (4) @(negedge clk);

        // req[2] and req_num[2] change mid-RUN: job completes with latched num.
        pend = 4'b0100; nums[2] = 6'd17; drive();
        wait_gnt(ok, gid, gv);
        chk("drop:gnt", 64'(gv), 64'b0100);
        rr_m = 3;
        repeat (10) @(negedge clk);
        pend = '0; nums[2] = 6'd50; drive();
        wait_done(ok, did, dcnt);
        chk("drop:done_seen", 64'(ok), 64'd1);
        chk("drop:done_id", 64'(did), 64'd2);
        chk("drop:done_cnt", 64'(dcnt), 64'd17);
        g0 = gnt_total;
        repeat (10) @(negedge clk);
        chk("drop:no_regrant", 64'(gnt_total - g0), 64'd0);

        // Reset mid-job around bit 30: silent abort, next grant starts at 0.
        pend = 4'b0010; nums[1] = 6'd40; drive();
        wait_gnt(ok, gid, gv);
        chk("abort:gnt", 64'(gv), 64'b0010);
        for (int c = 0; c < 1000 && sc_k < 30; c++) @(negedge clk);
        chk("abort:reach30", 64'(sc_k >= 30), 64'd1);
        pend = '0; drive();
        d0 = done_total;
        rst = 1'b0;
        #1;
        chk("abort:outs", 64'({bus.gnt, bus.done, bus.busy, bus.sc_en_in, bus.done_id, bus.done_cnt, bus.sc_num}), 64'd0);
        chk("abort:sc_m", 64'(bus.sc_m), 64'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1; rr_m = 0;
        repeat (5) @(negedge clk);
        chk("abort:no_done", 64'(done_total - d0), 64'd0);
        pend = 4'b1111; drive();
        run_job("post_rst");
        pend = '0; drive();
        repeat (4) @(negedge clk);

        // Generator stalls: watchdog fires, or job waits indefinitely.
        stall = 1; pend = 4'b0001; drive();
        wait_gnt(ok, gid, gv);
        chk("stall:gnt", 64'(gv), 64'b0001);
        lat = 0; lcnt = -1; lerr = -1;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (bus.done && lat == 0) begin
                lat  = c;
                lcnt = int'(bus.done_cnt);
`ifdef SC_STREAM_SCHED_WDOG_EN
                lerr = int'(bus.err);
`endif
                pend = '0; drive();
            end
        end
`ifdef SC_STREAM_SCHED_WDOG_EN
        chk("wdog:latency", 64'(lat), 64'(TO_CYC));
        chk("wdog:err", 64'(lerr), 64'd1);
        chk("wdog:cnt", 64'(lcnt), 64'd0);
`else
        chk("stall:no_done", 64'(lat), 64'd0);
        chk("stall:busy", 64'(bus.busy), 64'd1);
        chk("stall:sc_en_in", 64'(bus.sc_en_in), 64'd1);
`endif
        stall = 0; pend = '0; drive();
        rst = 1'b0; @(negedge clk); rst = 1'b1;
        repeat (3) @(negedge clk);

        chk("mon:gap", 64'(gap_viol), 64'd0);
        chk("mon:proto", 64'(proto_viol), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/sc_stream_sched.md
Name: sc_stream_sched

Overview:
- Round-robin scheduler that shares one stochastic-computing (SC) bitstream generator (Sobol-based, 6-bit num, 36-bit direction vectors) among NREQ requesters.
- Per job: grants one requester, loads its num and direction vectors into the generator, and runs LEN valid stream bits. It then counts the ones and returns the count to that requester.
- Sits between the SC consumers and the single SC/Sobol instance.

Parameters:
NREQ, 4, number of requesters (2..8)
LEN, 64, valid stream bits per job (1..64)
CW, 7, count width, must hold LEN (clog2(LEN+1))
TO_CYC, 255, watchdog limit in cycles (used only with the optional feature)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  asynchronous active-low reset
req  in  NREQ  level request per requester; held until matching done
req_num  in  NREQ*6  requester i num in bits [6i+5:6i]
cfg_m  in  36  direction-vector set, sampled at grant
gnt  out  NREQ  one-hot, one-cycle pulse at job start
done  out  1  one-cycle pulse at job end
done_id  out  3  index of finished requester, valid with done
done_cnt  out  CW  ones counted, valid with done
busy  out  1  high from GRANT through DONE
sc_en_in  out  1  enable to SC generator; low restarts its sequence
sc_num  out  6  num to SC generator
sc_m  out  36  direction vectors to SC generator
sc_en_out  in  1  SC bit-valid strobe
sc_seq  in  1  SC stream bit, sampled only when sc_en_out=1

Behaviour:
- Reset (rst=0, async):
  - state=IDLE; all outputs 0; rr pointer=0; counters 0.
  - Reset mid-job aborts silently: no done is issued.
- States: IDLE -> GRANT -> RUN -> DONE -> IDLE.
- IDLE:
  - sc_en_in=0.
  - If any req bit is set, select the first set bit scanning from rr pointer upward (wrapping), then go to GRANT.
- GRANT (1 cycle):
  - gnt[sel]=1, busy=1.
  - Latch sel, req_num[sel] into sc_num, and cfg_m into sc_m.
  - Clear vcnt and ones.
  - rr pointer = sel+1 mod NREQ.
- RUN:
  - sc_en_in=1; sc_num and sc_m are held constant.
  - Each cycle with sc_en_out=1: vcnt++; ones += sc_seq.
  - When the increment makes vcnt==LEN, go to DONE. That final bit is included in the count.
- DONE (1 cycle):
  - sc_en_in=0; done=1; done_id=sel; done_cnt=ones; busy stays 1.
  - Then go to IDLE.
- Gap: sc_en_in is low for at least 2 consecutive cycles between jobs (DONE + IDLE), so the generator always restarts from its first sequence point.
- Latency: done arrives GRANT + (SC pipeline delay) + LEN valid strobes + 1.
- Req changes outside IDLE:
  - Ignored during GRANT/RUN/DONE.
  - A requester dropping req mid-job does not abort; done is still issued.
  - req_num changes after GRANT have no effect.
- A requester whose req is still high after its done competes again. Round-robin guarantees every other pending requester is served first.
- All req=0 in IDLE: remain in IDLE, outputs quiet.
- ones never exceeds LEN, so CW is sufficient and no saturation is needed.
- done_id, done_cnt hold their last values after done falls. Consumers must use them only with done.

Optional Feature:
- Macro: SC_STREAM_SCHED_WDOG_EN.
- With macro defined:
  - Adds output err (1 bit, reset 0).
  - A cycle counter starts at GRANT and is cleared on every sc_en_out=1.
  - If it reaches TO_CYC in RUN, go to DONE with done=1, err=1, and done_cnt = partial ones.
  - err pulses with done only.
- Without macro: no err port, no watchdog. RUN waits indefinitely for LEN strobes.

Test Plan:
- Single requester, LEN=64, req[0]=1, num=0 with the real SC instance -> gnt=0001, one done, done_id=0, done_cnt=0.
- Single requester, LEN=64, num=63 then num=32 (full Sobol period) -> done_cnt=63 then 32. sc_en_in is low for at least 2 cycles between the jobs.
- All four req held high, nums 10/20/30/40 -> grants in order 0,1,2,3,0…, with done_cnt 10,20,30,40 and matching done_id.
- req[2] dropped and req_num[2] changed mid-RUN -> job completes, done_id=2, count reflects the num latched at GRANT.
- rst pulsed low at vcnt=30 -> all outputs 0 immediately. No done is issued. The next job grants requester 0 first.
- With SC_STREAM_SCHED_WDOG_EN and TO_CYC=16, bench holds sc_en_out=0 -> done=1, err=1, done_cnt=0 sixteen cycles after GRANT. Without the macro, the same stimulus keeps busy high and no done is issued.
